// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and default widths for the FIR multiply-accumulate sequencer.
package fir_mac_sequencer_pkg;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int COEF_WIDTH_DEF = 18;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int NTAPS_DEF      = 256;
    localparam int OUT_WIDTH_DEF  = 24;
    localparam int OUT_SHIFT_DEF  = 17;

    // Guard bits from ADDR_WIDTH cover the worst-case sum over 2^ADDR_WIDTH taps.
    function automatic int acc_width(input int data_w, input int coef_w, input int addr_w);
        return data_w + coef_w + addr_w;
    endfunction

    localparam int ACC_WIDTH_DEF = acc_width(DATA_WIDTH_DEF, COEF_WIDTH_DEF, ADDR_WIDTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } fir_state_t;

endpackage

// File: rtl/fir_mac_sequencer_out_sat.sv
// Arithmetic right shift of the accumulator followed by saturation to OUT_WIDTH.
module fir_out_sat #(
    parameter int ACC_WIDTH = 50,
    parameter int OUT_WIDTH = 24,
    parameter int OUT_SHIFT = 17
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] sat
);

    localparam int HI_W = ACC_WIDTH - OUT_WIDTH + 1;
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] shifted;
    logic [HI_W-1:0]             hi;

    assign shifted = acc >>> OUT_SHIFT;
    assign hi      = shifted[ACC_WIDTH-1:OUT_WIDTH-1];

    // In range only when every bit above the output sign bit matches it.
    always_comb begin
        sat = shifted[OUT_WIDTH-1:0];
        if (!(&hi) && (|hi)) begin
            sat = shifted[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one FIR output per input sample over an external circular buffer
// and coefficient ROM, both with one-cycle read latency.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for in_strobe
// ST_WRITE | write sample to buffer, clear accumulator and tap counter
// ST_READ  | NTAPS cycles issuing buffer reads and coefficient addresses
// ST_DRAIN | last product lands in the accumulator
// ST_DONE  | out_strobe; take pending sample or new strobe, else idle
module fir_mac_sequencer
    import fir_mac_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NTAPS      = NTAPS_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int OUT_SHIFT  = OUT_SHIFT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_strobe,
    output logic signed [DATA_WIDTH-1:0] buf_data_in,
    output logic                         buf_wren,
    output logic                         buf_rden,
    input  logic signed [DATA_WIDTH-1:0] buf_data_out,
    output logic        [ADDR_WIDTH-1:0] coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_strobe,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH, ADDR_WIDTH);
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NTAPS - 1);

    fir_state_t                   state_q;
    fir_state_t                   state_nxt;
    logic        [ADDR_WIDTH-1:0] tap_q;
    logic signed [DATA_WIDTH-1:0] sample_q;
    logic signed [DATA_WIDTH-1:0] pend_q;
    logic                         pend_vld_q;
    logic                         mac_en_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [OUT_WIDTH-1:0]  sat_out;
    logic signed [OUT_WIDTH-1:0]  out_data_q;
    logic                         overrun_q;

    assign prod    = buf_data_out * coef_data;
    assign acc_sum = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    fir_out_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_out_sat (
        .acc (acc_sum),
        .sat (sat_out)
    );

    always_comb begin
        state_nxt   = state_q;
        buf_wren    = 1'b0;
        buf_rden    = 1'b0;
        buf_data_in = '0;
        coef_addr   = '0;
        out_strobe  = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (in_strobe) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                buf_wren    = 1'b1;
                buf_data_in = sample_q;
                state_nxt   = ST_READ;
            end
            ST_READ: begin
                buf_rden  = 1'b1;
                coef_addr = tap_q;
                if (tap_q == LAST_TAP) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_strobe = 1'b1;
                state_nxt  = (pend_vld_q || in_strobe) ? ST_WRITE : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_data = out_data_q;
    assign overrun  = overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tap_q      <= '0;
            sample_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            mac_en_q   <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            mac_en_q  <= (state_q == ST_READ);
            overrun_q <= in_strobe && pend_vld_q && (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (in_strobe) sample_q <= in_data;
                end
                ST_WRITE: begin
                    tap_q <= '0;
                end
                ST_READ: begin
                    tap_q <= tap_q + ADDR_WIDTH'(1);
                end
                ST_DONE: begin
                    if (pend_vld_q) begin
                        sample_q   <= pend_q;
                        pend_vld_q <= 1'b0;
                    end else if (in_strobe) begin
                        sample_q <= in_data;
                    end
                end
                default: begin
                end
            endcase

            // DONE either hands the strobe straight to sample_q or drops it.
            if (in_strobe && !pend_vld_q &&
                (state_q inside {ST_WRITE, ST_READ, ST_DRAIN})) begin
                pend_q     <= in_data;
                pend_vld_q <= 1'b1;
            end

            if (state_q == ST_WRITE) begin
                acc_q <= '0;
            end else if (mac_en_q) begin
                acc_q <= acc_sum;
            end

            if (state_q == ST_DRAIN) out_data_q <= sat_out;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with NTAPS=4, OUT_SHIFT=0; models the
// circular buffer and coefficient ROM, and scoreboards every out_strobe.
module tb_fir_mac_sequencer;

    localparam int NTAPS     = 4;
    localparam int OUT_SHIFT = 0;

    logic               clk;
    logic               reset;
    logic signed [23:0] in_data;
    logic               in_strobe;
    logic [23:0]        buf_data_in;
    logic               buf_wren;
    logic               buf_rden;
    logic signed [23:0] buf_data_out;
    logic [7:0]         coef_addr;
    logic signed [17:0] coef_data;
    logic [23:0]        out_data;
    logic               out_strobe;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;

    logic signed [23:0] mem [0:255];
    logic [7:0]         wp;
    logic [7:0]         rp;
    logic signed [17:0] coef_rom [0:255];

    int          hist[$];
    logic [23:0] sb[$];

    fir_mac_sequencer #(
        .DATA_WIDTH (24),
        .COEF_WIDTH (18),
        .ADDR_WIDTH (8),
        .NTAPS      (NTAPS),
        .OUT_WIDTH  (24),
        .OUT_SHIFT  (OUT_SHIFT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_strobe    (in_strobe),
        .buf_data_in  (buf_data_in),
        .buf_wren     (buf_wren),
        .buf_rden     (buf_rden),
        .buf_data_out (buf_data_out),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .out_data     (out_data),
        .out_strobe   (out_strobe),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circular buffer: read pointer restarts at the newest entry on each write.
    always @(posedge clk) begin
        if (reset) begin
            wp           <= '0;
            rp           <= '0;
            buf_data_out <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (buf_wren) begin
                mem[wp] <= buf_data_in;
                rp      <= wp;
                wp      <= wp + 8'd1;
            end
            if (buf_rden) begin
                buf_data_out <= mem[rp];
                rp           <= rp - 8'd1;
            end
        end
    end

    always @(posedge clk) coef_data <= coef_rom[coef_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_strobe", out_strobe, 0);
            end else begin
                check("sb_out_data", out_data, sb.pop_front());
            end
        end
    end

    task automatic accept(input int x);
        longint      sum;
        logic [23:0] e;
        hist.push_front(x);
        if (hist.size() > NTAPS) void'(hist.pop_back());
        sum = 0;
        for (int k = 0; k < hist.size(); k++) sum += longint'(coef_rom[k]) * longint'(hist[k]);
        sum = sum >>> OUT_SHIFT;
        if (sum > 64'sd8388607)       e = 24'h7FFFFF;
        else if (sum < -64'sd8388608) e = 24'h800000;
        else                          e = sum[23:0];
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_strobe = 1'b0;
        hist.delete();
        sb.delete();
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        coef_rom[0] = 18'(c0);
        coef_rom[1] = 18'(c1);
        coef_rom[2] = 18'(c2);
        coef_rom[3] = 18'(c3);
    endtask

    task automatic send(input int x);
        bit found;
        in_data   = 24'(x);
        in_strobe = 1'b1;
        accept(x);
        step();
        in_strobe = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_strobe === 1'b1) found = 1'b1;
        end
        check("out_strobe_timeout", found, 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_strobe = 1'b0;
        in_data   = '0;
        for (int i = 0; i < 256; i++) coef_rom[i] = '0;
        set_coefs(1, 2, 3, 4);

        // Reset held three cycles
        repeat (2) step();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_wren", buf_wren, 0);
        check("rst_rden", buf_rden, 0);
        check("rst_caddr", coef_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_strobe", out_strobe, 0);
        check("rst_overrun", overrun, 0);
        check("rst_buf_data_in", buf_data_in, 0);
        step();
        reset = 1'b0;
        step();

        // Single sample, cycle-exact control timing
        in_data   = 24'sd5;
        in_strobe = 1'b1;
        accept(5);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check("t1_wren", buf_wren, c == 1);
            check("t1_rden", buf_rden, c >= 2 && c <= 5);
            check("t1_caddr", coef_addr, (c >= 2 && c <= 5) ? c - 2 : 0);
            check("t1_ostb", out_strobe, c == 7);
            check("t1_busy", busy, c >= 1 && c <= 7);
            if (c == 1) check("t1_wdata", buf_data_in, 24'd5);
            step();
            in_strobe = 1'b0;
        end
        repeat (2) step();

        // Impulse response
        do_reset();
        send(1);
        repeat (4) send(0);

        // Back-to-back strobes: one pending, one dropped
        for (int c = 0; c <= 15; c++) begin
            in_strobe = (c < 3);
            case (c)
                0: begin in_data = 24'sd10;  accept(10); end
                1: begin in_data = -24'sd7;  accept(-7); end
                2: in_data = 24'sd100;
                default: in_data = '0;
            endcase
            @(negedge clk);
            check("t3_overrun", overrun, c == 3);
            check("t3_ostb", out_strobe, c == 7 || c == 14);
            check("t3_busy", busy, c >= 1 && c <= 14);
            step();
        end
        in_strobe = 1'b0;
        send(30);

        // Saturation at both rails
        do_reset();
        set_coefs(131071, 131071, 131071, 131071);
        send(8388607);
        do_reset();
        send(-8388607);
        check("t4_out_data_min", out_data, 24'h800000);

        // Reset mid-computation, together with a strobe
        do_reset();
        set_coefs(1, 2, 3, 4);
        send(3);
        for (int c = 0; c <= 5; c++) begin
            in_strobe = (c == 0 || c == 4);
            in_data   = (c == 0) ? 24'sd9 : 24'sd77;
            if (c == 4) begin
                reset = 1'b1;
                hist.delete();
                sb.delete();
            end
            if (c == 5) begin
                reset     = 1'b0;
                in_strobe = 1'b0;
            end
            @(negedge clk);
            if (c == 5) begin
                check("t5_busy", busy, 0);
                check("t5_wren", buf_wren, 0);
                check("t5_rden", buf_rden, 0);
                check("t5_caddr", coef_addr, 0);
                check("t5_ostb", out_strobe, 0);
                check("t5_out_data", out_data, 0);
                check("t5_overrun", overrun, 0);
            end else begin
                check("t5_busy_run", busy, c >= 1);
            end
            step();
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t5_no_strobe", out_strobe, 0);
            step();
        end
        in_data   = 24'sd6;
        in_strobe = 1'b1;
        accept(6);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check("t5_ostb_latency", out_strobe, c == 7);
            check("t5_wren_latency", buf_wren, c == 1);
            step();
            in_strobe = 1'b0;
        end

        check("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
